fir_acc_output_stage: RTL and testbench
=======================================

// Module: fir_acc_output_stage
// PURPOSE
//  Consumer end of the FIR MAC18x36 datapath. Takes the 68-bit signed accumulator on a
//  final-sum strobe, rounds and saturates it to an OUT_W-bit sample, and buffers the
//  result in a small FIFO. The FIFO drains over a valid/ready stream to the next stage.
//  It tolerates downstream back-pressure and reports saturation and drop events.
// PARAMETERS
//  ACC_W  68  accumulator width (signed)
//  OUT_W  24  output sample width (signed); legal range 2 <= OUT_W <= ACC_W-SHIFT
//  SHIFT  34  fractional LSBs dropped; 0 = no rounding, pure truncation/saturation
//  DEPTH  4   FIFO entries; must be a power of 2, >= 2
// PORTS
//  clock      in   1              rising-edge clock
//  reset      in   1              asynchronous, active-low reset
//  acc_in     in   ACC_W          signed accumulator value; sampled only when acc_valid=1
//  acc_valid  in   1              one-cycle strobe: acc_in holds a final FIR sum
//  clr_flags  in   1              synchronous clear of sticky flags
//  out_data   out  OUT_W          signed sample at FIFO head; 0 when out_valid=0
//  out_valid  out  1              FIFO not empty
//  out_ready  in   1              downstream accepts; pop when out_valid & out_ready
//  fill       out  $clog2(DEPTH)+1 current FIFO occupancy, 0..DEPTH
//  sat_flag   out  1              sticky: a result was saturated
//  ovf_flag   out  1              sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - pipeline valids, FIFO pointers, fill, sat_flag and ovf_flag all go to 0 immediately.
//   - out_valid=0 and out_data=0 immediately.
//   - FIFO RAM contents are don't-care.
//   - in-flight results are discarded.
//  Stage 1 (edge after acc_valid):
//   - r = sext(acc_in, ACC_W+1) + (SHIFT>0 ? 1<<(SHIFT-1) : 0).
//   - The extra bit makes the rounding add unable to wrap. Result is round-half-up (toward +inf).
//  Stage 2 (next edge):
//   - q = r >>> SHIFT (arithmetic).
//   - If q > 2^(OUT_W-1)-1, clamp to max and set sat. If q < -2^(OUT_W-1), clamp to min and set sat.
//   - The clamped value is pushed to the FIFO.
//  Latency: acc_valid at edge 0 -> out_valid=1 after edge 2, when the FIFO was empty.
//   - Back-to-back strobes are accepted every cycle; throughput is 1 per clock.
//  FIFO:
//   - first-word-fall-through; out_data = mem[rd_ptr] when not empty.
//   - pop = out_valid & out_ready. push = stage-2 valid.
//   - pointers are $clog2(DEPTH)+1 bits and wrap naturally; full = MSBs differ and the rest are equal.
//  Boundary conditions:
//   - push while full, no pop: sample dropped, ovf_flag<=1, contents unchanged.
//   - push and pop in the same cycle while full: both happen, fill unchanged, no drop.
//   - push and pop in the same cycle at fill 1..DEPTH-1: fill unchanged.
//   - push into an empty FIFO: out_valid rises on the following cycle. No same-cycle bypass.
//   - out_ready while empty: ignored.
//   - out_data must hold stable while out_valid=1 and out_ready=0.
//  Flags:
//   - sat_flag and ovf_flag stay set until clr_flags=1.
//   - clr_flags in the same cycle as a new sat/drop event: set wins, flag stays 1.
//  acc_valid during reset is ignored. The first strobe after deassertion is processed normally.
// TESTING
//  T1 acc_in=5<<34, strobe, out_ready=1 -> out_data=5, out_valid high exactly 2 edges after strobe.
//  T2 rounding:
//   - (5<<34)+(1<<33) -> 6
//   - -(5<<34)-(1<<33) -> -5
//   - (5<<34)+(1<<33)-1 -> 5
//  T3 saturation:
//   - 1<<60 -> 24'h7FFFFF, sat_flag=1
//   - -(1<<60) -> 24'h800000
//   - clr_flags -> sat_flag=0
//  T4 back-pressure:
//   - out_ready=0, 5 consecutive strobes with values 1..5 (<<34) -> fill=4, ovf_flag=1.
//   - then out_ready=1 -> drains 1,2,3,4 in order, one per cycle, fill returns to 0.
//  T5 full with a simultaneous pop:
//   - fill=4, assert out_ready with a new strobe arriving -> no drop, ovf_flag stays 0, fill stays 4.
//  T6 reset mid-stream:
//   - fill=3 plus 2 in flight, pull reset low mid-cycle -> out_valid=0 and fill=0 without a clock edge.
//   - after release, one strobe of 7<<34 -> only 7 is emitted.

Source files
------------

// File: rtl/fir_acc_output_stage.sv
// Output stage of the FIR MAC datapath: round-half-up and saturate the wide accumulator
// to an OUT_W sample, then buffer it in a first-word-fall-through FIFO for the next stage.
module fir_acc_output_stage #(
    parameter int ACC_W = 68,
    parameter int OUT_W = 24,
    parameter int SHIFT = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ACC_W-1:0]         acc_in,
    input  logic                     acc_valid,
    input  logic                     clr_flags,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     sat_flag,
    output logic                     ovf_flag
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [ACC_W:0] ONE_R = {{ACC_W{1'b0}}, 1'b1};
    localparam logic [ACC_W:0] RND   = (SHIFT > 0) ? (ONE_R << RSH) : '0;

    localparam logic signed [ACC_W:0] MAX_Q = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_Q = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    // Stage 1: one extra sign bit so the rounding add can never wrap.
    logic                    s1_valid;
    logic signed [ACC_W:0]   s1_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= acc_valid;
            if (acc_valid) begin
                s1_r <= {acc_in[ACC_W-1], acc_in} + RND;
            end
        end
    end

    // Stage 2: arithmetic shift, then clamp to the signed OUT_W range.
    logic signed [ACC_W:0]   q;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        q_clamp;
    logic                    sat_evt;

    assign q       = s1_r >>> SHIFT;
    assign sat_hi  = (q > MAX_Q);
    assign sat_lo  = (q < MIN_Q);
    assign sat_evt = s1_valid & (sat_hi | sat_lo);

    always_comb begin
        q_clamp = q[OUT_W-1:0];
        if (sat_hi) begin
            q_clamp = OUT_MAX;
        end else if (sat_lo) begin
            q_clamp = OUT_MIN;
        end
    end

    logic                    s2_valid;
    logic [OUT_W-1:0]        s2_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= q_clamp;
            end
        end
    end

    // Output handshake: out_valid means the FIFO head in out_data is a real sample;
    // a transfer happens on any rising edge where out_valid & out_ready are both 1.
    // out_data stays stable while out_valid=1 and out_ready=0; out_ready alone does nothing.
    logic [OUT_W-1:0]        mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = s2_valid & (~full | pop);
    assign drop    = s2_valid & full & ~pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= s2_data;
        end
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fill      = wr_ptr - rd_ptr;

    // A new event in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            sat_flag <= sat_evt | (sat_flag & ~clr_flags);
            ovf_flag <= drop | (ovf_flag & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_fir_acc_output_stage.sv
// Directed bench for fir_acc_output_stage: table of rounding/saturation vectors plus
// hand-written back-pressure, full-with-pop and mid-stream reset sequences.
module tb_fir_acc_output_stage;

    logic        clock;
    logic        reset;
    logic [67:0] acc_in;
    logic        acc_valid;
    logic        clr_flags;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill;
    logic        sat_flag;
    logic        ovf_flag;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q[$];

    typedef struct {
        string       name;
        logic [67:0] acc;
        logic [23:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[14];

    fir_acc_output_stage #(
        .ACC_W(68),
        .OUT_W(24),
        .SHIFT(34),
        .DEPTH(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .acc_in   (acc_in),
        .acc_valid(acc_valid),
        .clr_flags(clr_flags),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill     (fill),
        .sat_flag (sat_flag),
        .ovf_flag (ovf_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [67:0] sh34(input int v);
        logic [67:0] t;
        t = 68'(signed'(v));
        return t << 34;
    endfunction

    task automatic drain_expected(input string name);
        int n;
        n = exp_q.size();
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic [23:0] e;
            e = exp_q.pop_front();
            check({name, "_valid"}, 32'(out_valid), 32'd1);
            check({name, "_data"}, 32'(out_data), 32'(e));
            step();
        end
        check({name, "_empty_valid"}, 32'(out_valid), 32'd0);
        check({name, "_empty_fill"}, 32'(fill), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"t1_plain5",     sh34(5),                                    24'h000005, 1'b0};
        vecs[1]  = '{"t2_half_up",    sh34(5) + (68'(1) << 33),                   24'h000006, 1'b0};
        vecs[2]  = '{"t2_neg_half",   sh34(-5) - (68'(1) << 33),                  24'hFFFFFB, 1'b0};
        vecs[3]  = '{"t2_below_half", sh34(5) + (68'(1) << 33) - 68'(1),          24'h000005, 1'b0};
        vecs[4]  = '{"t3_sat_pos",    68'(1) << 60,                               24'h7FFFFF, 1'b1};
        vecs[5]  = '{"t3_sat_neg",    -(68'(1) << 60),                            24'h800000, 1'b1};
        vecs[6]  = '{"zero",          68'(0),                                     24'h000000, 1'b0};
        vecs[7]  = '{"max_exact",     68'(24'h7FFFFF) << 34,                      24'h7FFFFF, 1'b0};
        vecs[8]  = '{"max_plus1",     68'(1) << 57,                               24'h7FFFFF, 1'b1};
        vecs[9]  = '{"max_round_up",  (68'(24'h7FFFFF) << 34) + (68'(1) << 33),   24'h7FFFFF, 1'b1};
        vecs[10] = '{"min_exact",     -(68'(1) << 57),                            24'h800000, 1'b0};
        vecs[11] = '{"min_half",      -(68'(1) << 57) - (68'(1) << 33),           24'h800000, 1'b0};
        vecs[12] = '{"min_past_half", -(68'(1) << 57) - (68'(1) << 33) - 68'(1),  24'h800000, 1'b1};
        vecs[13] = '{"acc_most_pos",  {1'b0, {67{1'b1}}},                         24'h7FFFFF, 1'b1};

        reset     = 1'b1;
        acc_in    = '0;
        acc_valid = 1'b0;
        clr_flags = 1'b0;
        out_ready = 1'b0;

        // Reset with a strobe held active: the strobe must be ignored.
        #2;
        reset     = 1'b0;
        acc_valid = 1'b1;
        acc_in    = sh34(99);
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_ovf", 32'(ovf_flag), 32'd0);
        acc_valid = 1'b0;
        reset     = 1'b1;
        repeat (3) step();
        check("rst_strobe_ignored", 32'(out_valid), 32'd0);

        // Table: latency, rounding and saturation, one strobe per row.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            clr_flags = 1'b1;
            acc_in    = vecs[i].acc;
            acc_valid = 1'b1;
            step();
            clr_flags = 1'b0;
            acc_valid = 1'b0;
            check({vecs[i].name, "_lat0"}, 32'(out_valid), 32'd0);
            step();
            check({vecs[i].name, "_lat1"}, 32'(out_valid), 32'd0);
            step();
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, "_data"}, 32'(out_data), 32'(vecs[i].exp_data));
            check({vecs[i].name, "_sat"}, 32'(sat_flag), 32'(vecs[i].exp_sat));
            step();
            check({vecs[i].name, "_popped"}, 32'(out_valid), 32'd0);
        end

        // Sticky sat survives idle cycles, clr_flags clears it.
        vecs[0].acc = 68'(1) << 60;
        acc_in    = vecs[0].acc;
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
        repeat (5) step();
        check("t3_sat_sticky", 32'(sat_flag), 32'd1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("t3_sat_cleared", 32'(sat_flag), 32'd0);
        check("t3_ovf_clear", 32'(ovf_flag), 32'd0);

        // T4: back-pressure, fifth sample dropped.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            acc_in    = sh34(i);
            acc_valid = 1'b1;
            if (i <= 4) exp_q.push_back(24'(i));
            step();
        end
        acc_valid = 1'b0;
        step();
        step();
        check("t4_fill_full", 32'(fill), 32'd4);
        check("t4_ovf", 32'(ovf_flag), 32'd1);
        check("t4_hold_data0", 32'(out_data), 32'd1);
        step();
        check("t4_hold_data1", 32'(out_data), 32'd1);
        check("t4_hold_fill", 32'(fill), 32'd4);
        drain_expected("t4_drain");
        check("t4_ovf_still", 32'(ovf_flag), 32'd1);

        // T5: full FIFO, push and pop in the same cycle.
        clr_flags = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            acc_in    = sh34(i);
            acc_valid = 1'b1;
            step();
            clr_flags = 1'b0;
        end
        acc_in    = sh34(14);
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
        step();
        check("t5_fill_before", 32'(fill), 32'd4);
        check("t5_ovf_cleared", 32'(ovf_flag), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_fill_after", 32'(fill), 32'd4);
        check("t5_no_drop", 32'(ovf_flag), 32'd0);
        check("t5_head", 32'(out_data), 32'd11);
        for (int i = 11; i <= 14; i++) exp_q.push_back(24'(i));
        drain_expected("t5_drain");

        // T6: reset mid-stream with three stored and two in flight.
        for (int i = 20; i <= 24; i++) begin
            acc_in    = sh34(i);
            acc_valid = 1'b1;
            step();
        end
        acc_valid = 1'b0;
        check("t6_fill_pre", 32'(fill), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_fill", 32'(fill), 32'd0);
        check("t6_async_data", 32'(out_data), 32'd0);
        @(negedge clock);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        acc_in    = sh34(7);
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
        step();
        step();
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_data", 32'(out_data), 32'd7);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_only_one", 32'(out_valid), 32'd0);
        end
        check("t6_ovf", 32'(ovf_flag), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
